// File: rtl/cisc_pkg.sv
// Shared definitions for the instruction fetch path: opcode length field,
// length codes and fetch sequencer state encoding.
package cisc_pkg;

  localparam int unsigned LEN_FLD_MSB = 7;
  localparam int unsigned LEN_FLD_W   = 2;
  localparam int unsigned LEN_W       = 2;

  // Opcode[7:6] length field codes
  localparam logic [LEN_FLD_W-1:0] FLD_LEN1 = 2'b00;
  localparam logic [LEN_FLD_W-1:0] FLD_LEN2 = 2'b01;
  localparam logic [LEN_FLD_W-1:0] FLD_LEN3 = 2'b10;
  localparam logic [LEN_FLD_W-1:0] FLD_RSVD = 2'b11;

  // Instruction byte counts
  localparam logic [LEN_W-1:0] LEN_1B = 2'd1;
  localparam logic [LEN_W-1:0] LEN_2B = 2'd2;
  localparam logic [LEN_W-1:0] LEN_3B = 2'd3;

  typedef enum logic [1:0] {
    F_OP  = 2'd0,
    F_B1  = 2'd1,
    F_B2  = 2'd2,
    ISSUE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_len_dec.sv
// Opcode length-field decoder: maps opcode[7:6] to the instruction byte count.
module instr_len_dec
  import cisc_pkg::*;
(
  input  logic [LEN_FLD_W-1:0] len_fld,
  output logic [LEN_W-1:0]     len_c
);

  always_comb begin
    len_c = LEN_1B;
    unique case (len_fld)
      FLD_LEN1: len_c = LEN_1B;
      FLD_LEN2: len_c = LEN_2B;
      FLD_LEN3: len_c = LEN_3B;
      FLD_RSVD: len_c = LEN_1B;
      default:  len_c = LEN_1B;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads opcode and operand bytes at the PC, loads
// the opcode into ir and issues the complete instruction over valid/ready.
module instr_fetch
  import cisc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_rdy,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  ir_ld,
  output logic [DATA_W-1:0]     ir_in,
  output logic [2*DATA_W-1:0]   opnd,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  pc_ld,
  input  logic [ADDR_W-1:0]     pc_in,
  output logic [ADDR_W-1:0]     pc
);

  localparam int unsigned OPND_W = 2 * DATA_W;

  fetch_state_e           state, state_nxt;
  logic [ADDR_W-1:0]      pc_nxt;
  logic [DATA_W-1:0]      ir_in_nxt;
  logic [OPND_W-1:0]      opnd_nxt;
  logic                   ir_ld_nxt;
  logic                   valid_nxt;
  logic [LEN_FLD_W-1:0]   len_fld;
  logic [LEN_W-1:0]       len_c;

  // In F_OP the length comes from the byte being loaded; later from the held opcode
  assign len_fld = (state == F_OP) ? mem_data[LEN_FLD_MSB -: LEN_FLD_W]
                                   : ir_in[LEN_FLD_MSB -: LEN_FLD_W];

  instr_len_dec u_len_dec (
    .len_fld (len_fld),
    .len_c   (len_c)
  );

  assign mem_rd   = (state != ISSUE);
  assign mem_addr = pc;

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= F_OP;
      pc          <= RESET_PC;
      ir_in       <= '0;
      ir_ld       <= 1'b0;
      opnd        <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir_in       <= ir_in_nxt;
      ir_ld       <= ir_ld_nxt;
      opnd        <= opnd_nxt;
      instr_valid <= valid_nxt;
    end
  end

  // Next-state and next-output logic; a jump overrides any byte arriving this cycle
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_in_nxt = ir_in;
    ir_ld_nxt = 1'b0;
    opnd_nxt  = opnd;
    valid_nxt = instr_valid;

    if (pc_ld) begin
      pc_nxt    = pc_in;
      state_nxt = F_OP;
      valid_nxt = 1'b0;
    end else begin
      unique case (state)
        F_OP: begin
          if (mem_rdy) begin
            ir_in_nxt = mem_data;
            ir_ld_nxt = 1'b1;
            opnd_nxt  = '0;
            pc_nxt    = pc + ADDR_W'(1);
            if (len_c == LEN_1B) begin
              state_nxt = ISSUE;
              valid_nxt = 1'b1;
            end else begin
              state_nxt = F_B1;
            end
          end
        end
        F_B1: begin
          if (mem_rdy) begin
            opnd_nxt[DATA_W-1:0] = mem_data;
            pc_nxt               = pc + ADDR_W'(1);
            if (len_c == LEN_3B) begin
              state_nxt = F_B2;
            end else begin
              state_nxt = ISSUE;
              valid_nxt = 1'b1;
            end
          end
        end
        F_B2: begin
          if (mem_rdy) begin
            opnd_nxt[OPND_W-1:DATA_W] = mem_data;
            pc_nxt                    = pc + ADDR_W'(1);
            state_nxt                 = ISSUE;
            valid_nxt                 = 1'b1;
          end
        end
        ISSUE: begin
          if (instr_valid && instr_ready) begin
            state_nxt = F_OP;
            valid_nxt = 1'b0;
          end
        end
        default: state_nxt = F_OP;
      endcase
    end
  end

endmodule
